prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/loader_addr_cnt.sv | 31 +++
 rtl/prog_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: default widths for the
// fetch path, the loader state encoding and a small state helper.
package prog_loader_pkg;

  localparam int DEF_AW = 12;
  localparam int DEF_DW = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // True in the states where the loader is consuming bytes.
  function automatic logic is_active(input logic [1:0] st);
    return (st == ST_LOAD) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/loader_addr_cnt.sv
// Loadable W-bit counter used both as the write address (counting up,
// wrapping naturally from all-ones back to zero) and as the remaining
// byte count (counting down).
module loader_addr_cnt
  import prog_loader_pkg::*;
#(
  parameter int W = DEF_AW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         down,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] STEP = W'(1);

  // Load has priority over counting; the wrap comes free from modulo-2^W arithmetic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= down ? (q - STEP) : (q + STEP);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts a stream of program bytes after a start request
// and writes them to consecutive program-memory addresses, one write
// issued the cycle after each accepted byte, then pulses done.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing
// checksum byte compared against the modulo-256 sum of the program bytes;
// a mismatch raises err, which stays set until the next accepted start.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] length,
  input  logic          in_valid,
  input  logic [DW-1:0] in_byte,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] LAST_ONE = AW'(1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] addr;
  logic [AW-1:0] count;
  logic          start_acc;
  logic          xfer;
  logic          last_xfer;

  // Start only counts in IDLE; anything arriving while busy or finishing is dropped.
  assign start_acc = (state == ST_IDLE) && start;
  assign xfer      = (state == ST_LOAD) && in_valid;
  assign last_xfer = xfer && (count == LAST_ONE);

`ifdef PROG_LOADER_CHECKSUM_EN
  assign in_ready = is_active(state);
`else
  assign in_ready = (state == ST_LOAD);
`endif
  assign busy = is_active(state);

  loader_addr_cnt #(.W(AW)) u_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val (base_addr),
    .en       (xfer),
    .down     (1'b0),
    .q        (addr)
  );

  loader_addr_cnt #(.W(AW)) u_count (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val (length),
    .en       (xfer),
    .down     (1'b1),
    .q        (count)
  );

  // Next-state selection; an empty program skips straight to the done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_FIN;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (in_valid) begin
          state_nxt = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered write port: one write per accepted byte, one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= xfer;
      if (xfer) begin
        mem_addr  <= addr;
        mem_wdata <= in_byte;
      end
    end
  end

  // Done is registered off FIN so it trails the final write by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= (state == ST_FIN);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
  logic       chk_xfer;
  logic       err_q;

  assign chk_xfer = (state == ST_CHECK) && in_valid;
  assign err      = err_q;

  // Running modulo-256 sum of the program bytes, restarted on each load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (start_acc) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + 8'(in_byte);
    end
  end

  // Sticky error flag, cleared only when the next load is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if (chk_xfer && (8'(in_byte) != checksum)) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
